// File: rtl/residue_mod_accum_pkg.sv
// Shared definitions for the residue modular accumulator: default sizes,
// FSM state encoding, tag pipe entry and a saturating increment helper.
package residue_mod_accum_pkg;

  localparam int DEF_DATA_WIDTH   = 18;
  localparam int DEF_MODULUS      = 177147;
  localparam int DEF_MULT_LATENCY = 6;
  localparam int DEF_CNT_WIDTH    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    if (value >= max_value) begin
      return max_value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/residue_mod_accum_add.sv
// Combinational residue adder: a + b with one conditional subtract of MODULUS.
// Both operands must already be reduced (< MODULUS) for the result to be reduced.
module mod_add_cond
  import residue_mod_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MODULUS    = DEF_MODULUS
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  localparam logic [DATA_WIDTH:0] MOD_EXT = (DATA_WIDTH+1)'(MODULUS);

  logic [DATA_WIDTH:0] raw;

  // One extra bit holds the carry so the compare sees the true sum
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    if (raw >= MOD_EXT) begin
      sum = DATA_WIDTH'(raw - MOD_EXT);
    end else begin
      sum = raw[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/residue_mod_accum.sv
// Streaming modular accumulator behind the constant modular multiplier; delays
// the valid/last tags to line up with the multiplier result and sums per vector.
module residue_mod_accum
  import residue_mod_accum_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MODULUS      = DEF_MODULUS,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] prod,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  err_range,
  output logic                  err_overflow
);

  localparam logic [DATA_WIDTH-1:0] MOD_W    = DATA_WIDTH'(MODULUS);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL = '1;

  tag_t                  tag_pipe [MULT_LATENCY];
  tag_t                  d_tag;
  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  prod_ok;
  logic [DATA_WIDTH-1:0] term;
  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] sum;

  // Tag pipe; last is qualified by valid on entry so a stray in_last never propagates
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MULT_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= {in_valid, in_valid & in_last};
      for (int i = 1; i < MULT_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign d_tag = tag_pipe[MULT_LATENCY-1];

  // Out-of-range products contribute zero so the adder operands stay reduced
  always_comb begin
    prod_ok  = (prod < MOD_W);
    if (prod_ok) begin
      term = prod;
    end else begin
      term = '0;
    end
    if (state == ACCUM) begin
      base = acc;
    end else begin
      base = '0;
    end
    cnt_next = CNT_WIDTH'(sat_inc(32'(cnt), 32'(CNT_FULL)));
  end

  mod_add_cond #(
    .DATA_WIDTH(DATA_WIDTH),
    .MODULUS   (MODULUS)
  ) u_add (
    .a  (base),
    .b  (term),
    .sum(sum)
  );

  // Vector FSM, running sum/count and registered result with sticky errors
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      err_range    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (d_tag.valid) begin
        if (!prod_ok) begin
          err_range <= 1'b1;
        end
        if (cnt == CNT_FULL) begin
          err_overflow <= 1'b1;
        end
        if (d_tag.last) begin
          out_data  <= sum;
          out_count <= cnt_next;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          acc       <= sum;
          cnt       <= cnt_next;
          state     <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_residue_mod_accum.sv
// Self-checking bench: directed vectors from the test plan plus random vectors,
// compared against a per-vector sum/count reference model with a timing scoreboard.
module tb_residue_mod_accum;

  localparam int DW   = 18;
  localparam int M    = 177147;
  localparam int ML   = 6;
  localparam int CW   = 8;
  localparam int CW_S = 2;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int CMAX_S = (1 << CW_S) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_last;
  logic [DW-1:0]   opnd;
  logic [DW-1:0]   prod;
  logic            out_valid, out_valid_s;
  logic [DW-1:0]   out_data, out_data_s;
  logic [CW-1:0]   out_count;
  logic [CW_S-1:0] out_count_s;
  logic            err_range, err_range_s;
  logic            err_overflow, err_overflow_s;

  residue_mod_accum #(.DATA_WIDTH(DW), .MODULUS(M), .MULT_LATENCY(ML), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .prod(prod),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .err_range(err_range), .err_overflow(err_overflow)
  );

  residue_mod_accum #(.DATA_WIDTH(DW), .MODULUS(M), .MULT_LATENCY(ML), .CNT_WIDTH(CW_S)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .prod(prod),
    .out_valid(out_valid_s), .out_data(out_data_s), .out_count(out_count_s),
    .err_range(err_range_s), .err_overflow(err_overflow_s)
  );

  always #5 clk = ~clk;

  // Stand-in for the multiplier: the chosen product emerges ML cycles after its operand
  logic [DW-1:0] mult_dly [ML];
  always @(posedge clk) begin
    mult_dly[0] <= opnd;
    for (int i = 1; i < ML; i++) mult_dly[i] <= mult_dly[i-1];
  end
  assign prod = mult_dly[ML-1];

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int data;
    int cnt;
    int cnt_s;
    int cyc;
  } exp_t;

  exp_t   exp_q[$];
  longint acc_m;
  int     n_m;
  bit     err_range_m, err_ovf_m, err_ovf_s_m;
  int     last_data, last_cnt, last_cnt_s;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    acc_m = 0; n_m = 0;
    err_range_m = 1'b0; err_ovf_m = 1'b0; err_ovf_s_m = 1'b0;
    last_data = 0; last_cnt = 0; last_cnt_s = 0;
  endtask

  task automatic drive_term(input int val, input bit last);
    exp_t e;
    in_valid = 1'b1;
    in_last  = last;
    opnd     = val[DW-1:0];
    n_m++;
    if (val < M) acc_m += val;
    else err_range_m = 1'b1;
    if (n_m > CMAX)   err_ovf_m   = 1'b1;
    if (n_m > CMAX_S) err_ovf_s_m = 1'b1;
    if (last) begin
      e.data  = int'(acc_m % M);
      e.cnt   = (n_m > CMAX)   ? CMAX   : n_m;
      e.cnt_s = (n_m > CMAX_S) ? CMAX_S : n_m;
      e.cyc   = cyc + 1 + ML;
      exp_q.push_back(e);
      acc_m = 0;
      n_m   = 0;
    end
    tick();
  endtask

  task automatic idle(input bit junk_last);
    in_valid = 1'b0;
    in_last  = junk_last;
    opnd     = DW'($urandom);
    tick();
  endtask

  task automatic drain_and_check_flags(input string tag);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1'b0);
    idle(1'b0);
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_err_range"}, err_range, err_range_m);
    check({tag, "_err_ovf"}, err_overflow, err_ovf_m);
    check({tag, "_err_ovf_s"}, err_overflow_s, err_ovf_s_m);
    check({tag, "_hold_data"}, out_data, last_data);
    check({tag, "_hold_count"}, out_count, last_cnt);
    check({tag, "_out_valid_low"}, out_valid, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; opnd = '0;
    tick();
    model_clear();
    check({tag, "_rst_valid"}, {out_valid, out_valid_s}, 2'b00);
    check({tag, "_rst_data"}, out_data, 0);
    check({tag, "_rst_count"}, out_count, 0);
    check({tag, "_rst_errs"}, {err_range, err_overflow, err_range_s, err_overflow_s}, 4'b0000);
    for (int i = 0; i < ML; i++) tick();
    reset = 1'b0;
    tick();
  endtask

  // Scoreboard: every pulse must match the oldest expected vector, on its exact cycle
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (out_valid || out_valid_s)) begin
      check("pulse_sync", out_valid_s, out_valid);
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_pulse: observed pulse at cycle %0d expected none", cyc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("out_data", out_data, e.data);
        check("out_count", out_count, e.cnt);
        check("out_data_s", out_data_s, e.data);
        check("out_count_s", out_count_s, e.cnt_s);
        last_data = e.data; last_cnt = e.cnt; last_cnt_s = e.cnt_s;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, val, gap;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; opnd = '0;
    model_clear();
    do_reset("init");

    // 100000+100000+50000 = 250000 -> 72853
    drive_term(100000, 1'b0);
    drive_term(100000, 1'b0);
    drive_term(50000, 1'b1);
    drain_and_check_flags("three_term");
    check("three_term_const", {out_count, out_data}, {8'd3, 18'd72853});

    drive_term(5, 1'b1);
    drain_and_check_flags("single");
    check("single_const", {out_count, out_data}, {8'd1, 18'd5});

    drive_term(177146, 1'b0);
    drive_term(1, 1'b1);
    drain_and_check_flags("wrap");
    check("wrap_const", {out_count, out_data}, {8'd2, 18'd0});

    // Back-to-back: pulses land on consecutive cycles via the latency check
    drive_term(7, 1'b0);
    drive_term(8, 1'b1);
    drive_term(9, 1'b1);
    drain_and_check_flags("b2b");
    check("b2b_const", {out_count, out_data}, {8'd1, 18'd9});

    drive_term(10, 1'b0);
    drive_term(177147, 1'b0);
    drive_term(20, 1'b1);
    drain_and_check_flags("range");
    check("range_const", {err_range, out_count, out_data}, {1'b1, 8'd3, 18'd30});

    drive_term(50, 1'b0);
    drive_term(60, 1'b0);
    do_reset("midvec");
    drive_term(3, 1'b0);
    drive_term(4, 1'b1);
    drain_and_check_flags("after_reset");
    check("after_reset_const", {err_range, out_count, out_data}, {1'b0, 8'd2, 18'd7});

    for (int i = 0; i < 5; i++) drive_term(1, i == 4);
    drain_and_check_flags("overflow");
    check("overflow_small_const", {err_overflow_s, out_count_s, out_data_s}, {1'b1, 2'd3, 18'd5});

    do_reset("pre_random");
    for (int v = 0; v < 40; v++) begin
      len = int'($urandom_range(1, 6));
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 15) == 0) val = int'($urandom_range(M, (1 << DW) - 1));
        else val = int'($urandom_range(0, M - 1));
        drive_term(val, t == len - 1);
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle($urandom_range(0, 1) == 1);
    end
    drain_and_check_flags("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/residue_mod_accum.md
# residue_mod_accum

Streaming modular accumulator directly downstream of the constant modular multiplier: sums the multiplier's residue products over a tagged vector, modulo MODULUS, and emits one residue dot-product per vector. The multiplier carries no valid/tag, so this block carries `in_valid`/`in_last`, applied alongside the multiplier's operand, through a MULT_LATENCY-deep shift register and pairs them with the multiplier's `result`.

## Interface
- DATA_WIDTH, 18, residue width
- MODULUS, 177147, residue modulus (3^11); must be < 2^DATA_WIDTH
- MULT_LATENCY, 6, cycles from multiplier operand to its `result`
- CNT_WIDTH, 8, term-counter width

- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand presented to multiplier this cycle
- in_last  in  1  operand is final term of vector (qualified by in_valid)
- prod  in  DATA_WIDTH  multiplier `result`
- out_valid  out  1  one-cycle pulse, out_data/out_count valid
- out_data  out  DATA_WIDTH  vector sum mod MODULUS
- out_count  out  CNT_WIDTH  terms accumulated in vector
- err_range  out  1  sticky: an accepted prod ≥ MODULUS
- err_overflow  out  1  sticky: term count saturated

## Operation
- Tag pipe: {valid,last} shifted MULT_LATENCY stages; stage output (d_valid, d_last) qualifies prod in same cycle.
- States: IDLE (no open vector, acc=0, cnt=0), ACCUM (vector open).
- Term value t = prod if prod < MODULUS, else 0 and err_range←1.
- Base b = 0 in IDLE, acc in ACCUM. s = b + t (DATA_WIDTH+1 bits); r = s − MODULUS if s ≥ MODULUS else s. Single conditional subtract suffices because both operands are < MODULUS.
- d_valid & !d_last: acc←r, cnt←sat(cnt+1), state→ACCUM.
- d_valid & d_last: out_data←r, out_count←sat(cnt+1), out_valid←1, acc←0, cnt←0, state→IDLE.
- !d_valid: hold; out_valid←0.
- Saturation: cnt at 2^CNT_WIDTH−1 holds and err_overflow←1; acc continues correctly.
- Back-to-back vectors: a term arriving the cycle after a last opens a new vector from base 0; no bubble required.
- in_last without in_valid ignored.

## Timing
- Reset values: out_valid 0, out_data 0, out_count 0, err_range 0, err_overflow 0; acc 0, cnt 0, state IDLE, tag pipe all 0.
- Reset mid-vector: in-flight tags and partial sum discarded; no out_valid for the dropped vector. The first valid ≥1 cycle after reset deasserts starts a new vector.
- Latency: out_valid asserted MULT_LATENCY+1 cycles after the cycle in_valid & in_last is sampled.
- Throughput: one term per cycle sustained; the accumulate loop is a single cycle.
- out_data/out_count hold between pulses; only out_valid qualifies them.
- Sticky errors clear only on reset.

## Structure
- Shared package: DATA_WIDTH/MODULUS defaults, state enum {IDLE, ACCUM}, saturating-increment function.
- Sub-module `mod_add_cond`: combinational b+t with conditional −MODULUS. It is also reused for any later residue adders.
- Top: tag shift register, FSM/acc/cnt registers, output and error registers.

## Test plan
- 3-term vector, prods 100000, 100000, 50000 (last on 3rd) -> out_data 72853, out_count 3, out_valid exactly MULT_LATENCY+1 cycles after 3rd in_valid.
- Single term prod 5 with in_last -> out_data 5, out_count 1; wrap: 177146 then 1 -> out_data 0, out_count 2.
- Back-to-back: vector {7,8 last} immediately followed by {9 last} -> pulses on consecutive cycles, 15/2 then 9/1.
- prod 177147 mid-vector {10, 177147, 20 last} -> err_range 1 (sticky), out_data 30, out_count 3.
- Reset asserted after 2 of 4 terms, then new vector {3,4 last} -> no pulse for the aborted vector; out_data 7, out_count 2; all outputs 0 during reset.
- CNT_WIDTH 2, 5-term vector of 1s -> out_count 3, err_overflow 1, out_data 5.
